// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, 16x oversampled start/data/stop sampling,
// registered byte output with a one-cycle completion strobe.
module uart_rx #(
  parameter int DBIT    = 8,   // data bits per frame, LSB first (5..8)
  parameter int SB_TICK = 16   // s_tick count for the stop period
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            busy
);

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_LAST = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [2:0]      n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic [DBIT-1:0] dout_next;
  logic            frame_err_next;
  logic            done_next;
  logic            rx_meta, rx_s;

  // Synchroniser presets to idle-high so leaving reset never reads as a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the pre-edge values,
      // giving a true two-stage pipeline; blocking here would collapse it to one.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      state        <= state_next;
      s            <= s_next;
      n            <= n_next;
      b            <= b_next;
      dout         <= dout_next;
      frame_err    <= frame_err_next;
      rx_done_tick <= done_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave
    // a variable unassigned and infer a latch.
    state_next     = state;
    s_next         = s;
    n_next         = n;
    b_next         = b;
    dout_next      = dout;
    frame_err_next = frame_err;
    done_next      = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            // Mid-start-bit check rejects glitches shorter than half a bit.
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + SW'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s == S_LAST) begin
            s_next = '0;
            b_next = {rx_s, b[DBIT-1:1]};
            if (n == N_LAST) state_next = STOP;
            else             n_next     = n + 3'd1;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            dout_next      = b;
            frame_err_next = ~rx_s;
            done_next      = 1'b1;
            state_next     = IDLE;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART serial receiver that consumes the one-clock-wide sampling tick from the team's baud-rate generator at 16x the bit rate. Sequence: synchronises the asynchronous `rx` line, detects the start bit, samples each data bit at mid-bit, checks the stop bit, then presents the received byte with a one-cycle done strobe. Sits between the rate generator and the receive FIFO / interface logic of the UART component.

Parameters:
DBIT, 8, number of data bits per frame (LSB first); legal 5..8
SB_TICK, 16, s_tick count for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
s_tick  input  1  16x oversampling tick from the rate generator, one clk wide
rx_done_tick  output  1  one-cycle strobe: frame complete, dout/frame_err valid
dout  output  DBIT  last received data word
frame_err  output  1  stop bit sampled low on last frame
busy  output  1  high while state != IDLE

Behaviour:
- Clock is `clk`; `reset` is asynchronous and active-high. All state is updated on posedge clk, with async clear on posedge reset.
- Reset values:
  - state = IDLE; tick counter s = 0; bit counter n = 0; shift reg b = 0.
  - dout = 0, rx_done_tick = 0, frame_err = 0, busy = 0.
  - Both synchroniser flops = 1, so reset never looks like a start bit.
- Input sync: `rx` passes through 2 flops to give rx_s. All decisions below use rx_s, which adds 2 clk of latency.
- State machine (s is 4 bits, or wider if SB_TICK > 16; n is 3 bits):
  - IDLE:
    - rx_s==0 -> START, s=0.
    - Otherwise stay. s_tick is ignored.
  - START: on s_tick:
    - If s==7 and rx_s==0 -> DATA, s=0, n=0 (mid-start-bit confirmed).
    - If s==7 and rx_s==1 -> IDLE. This is a glitch/false start: no strobe, dout unchanged.
    - Else s=s+1.
  - DATA: on s_tick:
    - If s==15: s=0, b={rx_s, b[DBIT-1:1]} (LSB first).
      - n==DBIT-1 -> STOP.
      - Otherwise n=n+1.
    - Else s=s+1.
  - STOP: on s_tick:
    - If s==SB_TICK-1: dout<=b, frame_err<=~rx_s, rx_done_tick<=1, -> IDLE.
    - Else s=s+1.
- No s_tick in any state: hold all counters.
- rx_done_tick:
  - Registered; high for exactly one clk, in the cycle after the edge that consumed the final stop tick.
  - Never high two cycles in a row.
- dout and frame_err change only on the edge that sets rx_done_tick, and hold until the next completed frame.
- A frame with a bad stop bit still strobes rx_done_tick and updates dout, with frame_err=1.
- Line held low (break):
  - Ends in STOP with frame_err=1, dout=0.
  - Then returns to IDLE, immediately sees rx_s==0 and re-enters START. No lock-up.
- Back-to-back frames: a start edge arriving in the cycle after the return to IDLE is accepted; no dead time beyond one clk.
- busy = (state != IDLE), combinational from the state register.
- Reset mid-frame: async return to IDLE and all reset values. The partial frame is discarded with no strobe.

Test Plan:
- Tie s_tick=1 (16 clk per bit). Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> one rx_done_tick, dout=0xA5, frame_err=0, busy low again 1 clk later.
- Same setup, send 0x3C then 0xFF with zero idle between frames -> two strobes, dout=0x3C then 0xFF, no missed or extra strobe.
- Same setup, send 0x55 with stop bit driven 0 -> strobe, dout=0x55, frame_err=1. Next good frame 0x12 -> frame_err=0.
- Pulse rx low for 4 bit-ticks only, then high -> returns to IDLE after 8 ticks, no strobe, dout unchanged.
- Real rate generator, s_tick every 27 clk. Send 0x81 with rx transitions skewed ±3 clk from nominal -> dout=0x81, frame_err=0.
- Assert reset during DATA after 3 bits -> busy=0, outputs at reset values, no strobe. Following frame 0x7E is received correctly.
